// File: rtl/shift_pipe_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the pipelined barrel shifter:
//   mode_e            - shift mode encodings (SLL, SRL, ROL, SRA)
//   SHAMT_IN_W        - width of the raw shift-amount field on the bus
//   levels_per_stage  - number of log-shift levels folded into each pipe stage
// -----------------------------------------------------------------------------
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_ROL = 2'b10,
    MODE_SRA = 2'b11
  } mode_e;

  localparam int SHAMT_IN_W = 8;

  // ceil(log2(width) / stages): levels are packed LSB-first, so trailing
  // stages may receive fewer levels (or none) and simply register the beat.
  function automatic int levels_per_stage(input int width, input int stages);
    int shamt_w;
    shamt_w = $clog2(width);
    return (shamt_w + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// -----------------------------------------------------------------------------
// shift_pipe_if
// Valid/ready bus for shift_pipe: an input channel (operand, amount, mode, tag)
// and an output channel (result, tag).
//   master : producer/consumer side (drives in_*, out_ready)
//   slave  : shifter side (drives in_ready, out_*)
// -----------------------------------------------------------------------------
interface shift_pipe_if
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic [SHAMT_IN_W-1:0] in_shamt;
  logic [1:0]            in_mode;
  logic [TAG_W-1:0]      in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [TAG_W-1:0]      out_tag;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/shift_pipe_level.sv
// -----------------------------------------------------------------------------
// shift_level
// One combinational level of the log shifter: shifts by the constant AMOUNT
// when enabled, otherwise passes data through.
//   i_data   - operand
//   i_enable - this level's shift-amount bit
//   i_mode   - SLL / SRL / SRA / ROL
//   i_sign   - original operand sign bit, used as SRA fill
//   o_data   - result
// -----------------------------------------------------------------------------
module shift_level
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int AMOUNT = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_enable,
  input  logic [1:0]       i_mode,
  input  logic             i_sign,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] w_shifted;

  always_comb begin
    // NOTE: default assignment first, so every path drives w_shifted and no latch is inferred.
    w_shifted = i_data;
    case (mode_e'(i_mode))
      MODE_SLL: w_shifted = i_data << AMOUNT;
      MODE_SRL: w_shifted = i_data >> AMOUNT;
      // Fill comes from the original sign, not this level's MSB, so the
      // result is right even if an earlier level already moved the bits.
      MODE_SRA: w_shifted = {{AMOUNT{i_sign}}, i_data[WIDTH-1:AMOUNT]};
      MODE_ROL: w_shifted = {i_data[WIDTH-1-AMOUNT:0], i_data[WIDTH-1:WIDTH-AMOUNT]};
      default:  w_shifted = i_data;
    endcase
  end

  assign o_data = i_enable ? w_shifted : i_data;

endmodule

// File: rtl/shift_pipe.sv
// -----------------------------------------------------------------------------
// shift_pipe
// Pipelined barrel shifter (SLL/SRL/SRA/ROL) with valid/ready handshake and a
// passthrough tag. Latency STAGES cycles, throughput one beat per cycle.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; flushes all in-flight beats
//   bus   - shift_pipe_if slave: in_* request channel, out_* result channel
// -----------------------------------------------------------------------------
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  shift_pipe_if.slave  bus
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int LPS     = levels_per_stage(WIDTH, STAGES);

  // Stage registers
  logic               r_valid [STAGES];
  logic [WIDTH-1:0]   r_data  [STAGES];
  logic [SHAMT_W-1:0] r_sh    [STAGES];
  logic [1:0]         r_mode  [STAGES];
  logic               r_sign  [STAGES];
  logic [TAG_W-1:0]   r_tag   [STAGES];

  // Per-stage inputs (bus for stage 0, previous register otherwise)
  logic               w_in_valid [STAGES];
  logic [WIDTH-1:0]   w_in_data  [STAGES];
  logic [SHAMT_W-1:0] w_in_sh    [STAGES];
  logic [1:0]         w_in_mode  [STAGES];
  logic               w_in_sign  [STAGES];
  logic [TAG_W-1:0]   w_in_tag   [STAGES];
  logic [WIDTH-1:0]   w_out_data [STAGES];

  logic w_adv;
  logic w_unused_shamt;

  // The whole pipe moves as one; it only holds when the output is blocked.
  assign w_adv          = !r_valid[STAGES-1] || bus.out_ready;
  assign bus.in_ready   = w_adv;
  assign bus.out_valid  = r_valid[STAGES-1];
  assign bus.out_data   = r_data[STAGES-1];
  assign bus.out_tag    = r_tag[STAGES-1];

  // Upper amount bits are masked off (RISC-V semantics).
  assign w_unused_shamt = ^bus.in_shamt[SHAMT_IN_W-1:SHAMT_W];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign w_in_valid[s] = bus.in_valid;
      assign w_in_data[s]  = bus.in_data;
      assign w_in_sh[s]    = bus.in_shamt[SHAMT_W-1:0];
      assign w_in_mode[s]  = bus.in_mode;
      assign w_in_sign[s]  = bus.in_data[WIDTH-1];
      assign w_in_tag[s]   = bus.in_tag;
    end else begin : g_body
      assign w_in_valid[s] = r_valid[s-1];
      assign w_in_data[s]  = r_data[s-1];
      assign w_in_sh[s]    = r_sh[s-1];
      assign w_in_mode[s]  = r_mode[s-1];
      assign w_in_sign[s]  = r_sign[s-1];
      assign w_in_tag[s]   = r_tag[s-1];
    end

    // Chain of this stage's levels; levels beyond SHAMT_W become wires.
    logic [WIDTH-1:0] w_chain [LPS+1];
    assign w_chain[0] = w_in_data[s];

    for (genvar k = 0; k < LPS; k++) begin : g_lvl
      localparam int LVL = s * LPS + k;
      if (LVL < SHAMT_W) begin : g_shift
        shift_level #(
          .WIDTH  (WIDTH),
          .AMOUNT (1 << LVL)
        ) u_level (
          .i_data   (w_chain[k]),
          .i_enable (w_in_sh[s][LVL]),
          .i_mode   (w_in_mode[s]),
          .i_sign   (w_in_sign[s]),
          .o_data   (w_chain[k+1])
        );
      end else begin : g_pass
        assign w_chain[k+1] = w_chain[k];
      end
    end

    assign w_out_data[s] = w_chain[LPS];
  end

  // The full amount travels with the beat; each stage only looks at its own
  // level bits, so already-consumed bits are simply ignored downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data and tag are reset too (not just valid), so out_data/out_tag read 0 during reset.
      for (int s = 0; s < STAGES; s++) begin
        r_valid[s] <= 1'b0;
        r_data[s]  <= '0;
        r_sh[s]    <= '0;
        r_mode[s]  <= '0;
        r_sign[s]  <= 1'b0;
        r_tag[s]   <= '0;
      end
    end else if (w_adv) begin
      // NOTE: non-blocking, so each stage captures its predecessor's pre-edge value.
      for (int s = 0; s < STAGES; s++) begin
        r_valid[s] <= w_in_valid[s];
        r_data[s]  <= w_out_data[s];
        r_sh[s]    <= w_in_sh[s];
        r_mode[s]  <= w_in_mode[s];
        r_sign[s]  <= w_in_sign[s];
        r_tag[s]   <= w_in_tag[s];
      end
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_pipe
// Self-checking bench for shift_pipe: a 32-bit/2-stage instance plus 64-bit
// instances with 1 and 5 stages. Directed vector tables with hand-computed
// results, then hand-written streaming, backpressure and reset sequences.
// -----------------------------------------------------------------------------
module tb_shift_pipe;
  import shift_pkg::*;

  typedef struct {
    mode_e       mode;
    logic [31:0] data;
    logic [7:0]  shamt;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec32_t;

  typedef struct {
    mode_e       mode;
    logic [63:0] data;
    logic [7:0]  shamt;
    logic [4:0]  tag;
    logic [63:0] exp;
  } vec64_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  vec32_t v32 [15];
  vec64_t v64 [9];

  always #5 clk = ~clk;

  shift_pipe_if #(.WIDTH(32), .TAG_W(5)) b32 ();
  shift_pipe_if #(.WIDTH(64), .TAG_W(5)) b1 ();
  shift_pipe_if #(.WIDTH(64), .TAG_W(5)) b5 ();

  shift_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  shift_pipe #(.WIDTH(64), .STAGES(1), .TAG_W(5)) u_dut1  (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  shift_pipe #(.WIDTH(64), .STAGES(5), .TAG_W(5)) u_dut5  (.clk(clk), .rst_n(rst_n), .bus(b5.slave));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    b32.in_valid = 1'b0;
    b1.in_valid  = 1'b0;
    b5.in_valid  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // One beat into the 32-bit pipe on an empty, unstalled pipe; latency counts
  // the accept edge as cycle 1.
  task automatic run32(input vec32_t v, input string name);
    int lat;
    bit got;
    logic [31:0] d;
    logic [4:0]  t;
    @(negedge clk);
    b32.in_valid = 1'b1;
    b32.in_data  = v.data;
    b32.in_shamt = v.shamt;
    b32.in_mode  = v.mode;
    b32.in_tag   = v.tag;
    check($sformatf("%s in_ready", name), 64'(b32.in_ready), 64'd1);
    lat = 0; got = 1'b0; d = '0; t = '0;
    while (!got && lat < 16) begin
      @(posedge clk); #1;
      lat++;
      b32.in_valid = 1'b0;
      if (b32.out_valid) begin
        got = 1'b1; d = b32.out_data; t = b32.out_tag;
      end
    end
    check($sformatf("%s seen", name), 64'(got), 64'd1);
    check($sformatf("%s latency", name), 64'(lat), 64'd2);
    check($sformatf("%s data", name), 64'(d), 64'(v.exp));
    check($sformatf("%s tag", name), 64'(t), 64'(v.tag));
  endtask

  // Same beat into both 64-bit pipes (1 and 5 stages).
  task automatic run64(input vec64_t v, input string name);
    int cyc, lat1, lat5;
    bit got1, got5;
    logic [63:0] d1, d5;
    logic [4:0]  t1, t5;
    @(negedge clk);
    b1.in_valid = 1'b1; b1.in_data = v.data; b1.in_shamt = v.shamt; b1.in_mode = v.mode; b1.in_tag = v.tag;
    b5.in_valid = 1'b1; b5.in_data = v.data; b5.in_shamt = v.shamt; b5.in_mode = v.mode; b5.in_tag = v.tag;
    cyc = 0; lat1 = 0; lat5 = 0; got1 = 1'b0; got5 = 1'b0;
    d1 = '0; d5 = '0; t1 = '0; t5 = '0;
    while (!(got1 && got5) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      b1.in_valid = 1'b0;
      b5.in_valid = 1'b0;
      if (!got1 && b1.out_valid) begin got1 = 1'b1; lat1 = cyc; d1 = b1.out_data; t1 = b1.out_tag; end
      if (!got5 && b5.out_valid) begin got5 = 1'b1; lat5 = cyc; d5 = b5.out_data; t5 = b5.out_tag; end
    end
    check($sformatf("%s s1 seen", name), 64'(got1), 64'd1);
    check($sformatf("%s s5 seen", name), 64'(got5), 64'd1);
    check($sformatf("%s s1 latency", name), 64'(lat1), 64'd1);
    check($sformatf("%s s5 latency", name), 64'(lat5), 64'd5);
    check($sformatf("%s s1 data", name), d1, v.exp);
    check($sformatf("%s s5 data", name), d5, v.exp);
    check($sformatf("%s s1 tag", name), 64'(t1), 64'(v.tag));
    check($sformatf("%s s5 tag", name), 64'(t5), 64'(v.tag));
  endtask

  task automatic stream_test();
    logic [31:0] rd [8];
    logic [4:0]  rt [8];
    int          rc [8];
    int          cnt;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin rd[k] = '0; rt[k] = '0; rc[k] = 0; end
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          b32.in_valid = 1'b1;
          b32.in_data  = 32'h1;
          b32.in_shamt = 8'(3 * k);
          b32.in_mode  = MODE_SLL;
          b32.in_tag   = 5'(k + 16);
        end
        @(negedge clk);
        b32.in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 20; c++) begin
          @(posedge clk); #1;
          if (b32.out_valid && cnt < 8) begin
            rd[cnt] = b32.out_data; rt[cnt] = b32.out_tag; rc[cnt] = c; cnt++;
          end
        end
      end
    join
    check("stream count", 64'(cnt), 64'd8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("stream[%0d] data", k), 64'(rd[k]), 64'(32'h1 << (3 * k)));
      check($sformatf("stream[%0d] tag", k), 64'(rt[k]), 64'(k + 16));
      check($sformatf("stream[%0d] cycle", k), 64'(rc[k]), 64'(rc[0] + k));
    end
  endtask

  task automatic drive32(input mode_e m, input logic [31:0] d, input logic [7:0] sh, input logic [4:0] t);
    b32.in_valid = 1'b1; b32.in_data = d; b32.in_shamt = sh; b32.in_mode = m; b32.in_tag = t;
  endtask

  // A = SLL 0x3 by 2 -> 0xC, B = SRL 0xF0 by 4 -> 0xF, C = ROL 0x80000000 by 1 -> 0x1
  task automatic backpressure_test();
    @(negedge clk);
    b32.out_ready = 1'b0;
    drive32(MODE_SLL, 32'h3, 8'd2, 5'd1);
    @(posedge clk); #1;
    @(negedge clk);
    drive32(MODE_SRL, 32'hF0, 8'd4, 5'd2);
    @(posedge clk); #1;
    check("bp head valid", 64'(b32.out_valid), 64'd1);
    check("bp in_ready low", 64'(b32.in_ready), 64'd0);
    @(negedge clk);
    drive32(MODE_ROL, 32'h8000_0000, 8'd1, 5'd3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold%0d valid", i), 64'(b32.out_valid), 64'd1);
      check($sformatf("bp hold%0d data", i), 64'(b32.out_data), 64'h0000_000C);
      check($sformatf("bp hold%0d tag", i), 64'(b32.out_tag), 64'd1);
      check($sformatf("bp hold%0d in_ready", i), 64'(b32.in_ready), 64'd0);
    end
    @(negedge clk);
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    check("bp drain B data", 64'(b32.out_data), 64'h0000_000F);
    check("bp drain B tag", 64'(b32.out_tag), 64'd2);
    @(posedge clk); #1;
    check("bp drain C valid", 64'(b32.out_valid), 64'd1);
    check("bp drain C data", 64'(b32.out_data), 64'h0000_0001);
    check("bp drain C tag", 64'(b32.out_tag), 64'd3);
    @(posedge clk); #1;
    check("bp empty", 64'(b32.out_valid), 64'd0);
  endtask

  task automatic reset_test();
    int stale;
    @(negedge clk);
    drive32(MODE_SLL, 32'h1, 8'd1, 5'd7);
    @(negedge clk);
    drive32(MODE_SLL, 32'h1, 8'd2, 5'd8);
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    check("rst in-flight valid", 64'(b32.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst async valid", 64'(b32.out_valid), 64'd0);
    check("rst async data", 64'(b32.out_data), 64'd0);
    check("rst async tag", 64'(b32.out_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (b32.out_valid) stale++;
    end
    check("rst no stale beat", 64'(stale), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    v32[0]  = '{MODE_SLL, 32'h0000_0001, 8'd31, 5'h0A, 32'h8000_0000};
    v32[1]  = '{MODE_SRA, 32'h8000_0000, 8'd4,  5'h01, 32'hF800_0000};
    v32[2]  = '{MODE_SRL, 32'h8000_0000, 8'd4,  5'h02, 32'h0800_0000};
    v32[3]  = '{MODE_ROL, 32'h8000_0001, 8'd1,  5'h03, 32'h0000_0003};
    v32[4]  = '{MODE_SLL, 32'h0000_0001, 8'd33, 5'h04, 32'h0000_0002};
    v32[5]  = '{MODE_SLL, 32'hDEAD_BEEF, 8'd0,  5'h05, 32'hDEAD_BEEF};
    v32[6]  = '{MODE_SRL, 32'hDEAD_BEEF, 8'd0,  5'h06, 32'hDEAD_BEEF};
    v32[7]  = '{MODE_SRA, 32'hDEAD_BEEF, 8'd0,  5'h07, 32'hDEAD_BEEF};
    v32[8]  = '{MODE_ROL, 32'hDEAD_BEEF, 8'd0,  5'h08, 32'hDEAD_BEEF};
    v32[9]  = '{MODE_SRA, 32'h8000_0000, 8'd32, 5'h09, 32'h8000_0000};
    v32[10] = '{MODE_ROL, 32'h1234_5678, 8'd8,  5'h1B, 32'h3456_7812};
    v32[11] = '{MODE_SRA, 32'h7FFF_FFF0, 8'd4,  5'h1C, 32'h07FF_FFFF};
    v32[12] = '{MODE_SRA, 32'h8000_0000, 8'd31, 5'h1D, 32'hFFFF_FFFF};
    v32[13] = '{MODE_ROL, 32'h8000_0000, 8'd31, 5'h1E, 32'h4000_0000};
    v32[14] = '{MODE_SLL, 32'hFFFF_FFFF, 8'd48, 5'h1F, 32'hFFFF_0000};

    v64[0] = '{MODE_SLL, 64'h0000_0000_0000_0001, 8'd63, 5'h0A, 64'h8000_0000_0000_0000};
    v64[1] = '{MODE_SRA, 64'h8000_0000_0000_0000, 8'd4,  5'h01, 64'hF800_0000_0000_0000};
    v64[2] = '{MODE_SRL, 64'h8000_0000_0000_0000, 8'd4,  5'h02, 64'h0800_0000_0000_0000};
    v64[3] = '{MODE_ROL, 64'h8000_0000_0000_0001, 8'd1,  5'h03, 64'h0000_0000_0000_0003};
    v64[4] = '{MODE_SLL, 64'h0000_0000_0000_0001, 8'd65, 5'h04, 64'h0000_0000_0000_0002};
    v64[5] = '{MODE_ROL, 64'h0123_4567_89AB_CDEF, 8'd4,  5'h05, 64'h1234_5678_9ABC_DEF0};
    v64[6] = '{MODE_SRA, 64'h8000_0000_0000_0000, 8'd63, 5'h06, 64'hFFFF_FFFF_FFFF_FFFF};
    v64[7] = '{MODE_SRA, 64'h8000_0000_0000_0000, 8'd0,  5'h07, 64'h8000_0000_0000_0000};
    v64[8] = '{MODE_SRL, 64'hFFFF_0000_0000_0000, 8'd40, 5'h08, 64'h0000_0000_00FF_FF00};

    rst_n = 1'b0;
    b32.in_valid = 1'b0; b32.in_data = '0; b32.in_shamt = '0; b32.in_mode = '0; b32.in_tag = '0; b32.out_ready = 1'b1;
    b1.in_valid  = 1'b0; b1.in_data  = '0; b1.in_shamt  = '0; b1.in_mode  = '0; b1.in_tag  = '0; b1.out_ready  = 1'b1;
    b5.in_valid  = 1'b0; b5.in_data  = '0; b5.in_shamt  = '0; b5.in_mode  = '0; b5.in_tag  = '0; b5.out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset w32 out_valid", 64'(b32.out_valid), 64'd0);
    check("reset w32 out_data", 64'(b32.out_data), 64'd0);
    check("reset w32 in_ready", 64'(b32.in_ready), 64'd1);
    check("reset s1 out_valid", 64'(b1.out_valid), 64'd0);
    check("reset s5 out_valid", 64'(b5.out_valid), 64'd0);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 15; i++) run32(v32[i], $sformatf("v32[%0d]", i));
    idle(3);
    for (int i = 0; i < 9; i++) run64(v64[i], $sformatf("v64[%0d]", i));
    idle(6);

    stream_test();
    idle(3);
    backpressure_test();
    idle(3);
    reset_test();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
